router_fifo: RTL and testbench



---
 rtl/router_fifo.sv | 88 ++++++++
 tb/tb_router_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-destination output buffer for the 1x3 router: a tagged-byte FIFO with packet-length
// tracking so data_out falls back to zero once the current packet has been drained.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [6:0]       pkt_count_q, pkt_count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH:0]   rd_entry;
    logic             do_wr, do_rd;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign data_out = data_out_q;

    // Flags are taken before the edge, so a full FIFO only reads and an empty one only writes.
    assign do_wr = write_enb && !full  && !soft_reset;
    assign do_rd = read_enb  && !empty && !soft_reset;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_count_d = pkt_count_q;
        data_out_d  = data_out_q;
        if (soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = '0;
            data_out_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_entry[WIDTH-1:0];
                // Header reload counts payload plus the trailing parity byte.
                if (rd_entry[WIDTH]) begin
                    pkt_count_d = {1'b0, rd_entry[7:2]} + 7'd1;
                end else if (pkt_count_q != 7'd0) begin
                    pkt_count_d = pkt_count_q - 7'd1;
                end
            end else if (pkt_count_q == 7'd0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            data_out_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            data_out_q  <= data_out_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are meaningful.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, packet drain, full/empty boundaries,
// concurrent read/write, flush, and a randomly gapped stream across pointer wrap.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mdl_q[$];
    bit         exp_rd_valid, exp_wr_valid;
    logic [7:0] exp_rd_data;

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clock(clock), .reset(reset), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    // Drive one cycle, advance the occupancy model, sample 1 time unit after the edge.
    task automatic step(input bit wr, input bit rd, input bit lfd, input logic [7:0] din);
        write_enb = wr;
        read_enb = rd;
        lfd_state = lfd;
        data_in = din;
        exp_wr_valid = wr && (mdl_q.size() < 16) && !soft_reset;
        exp_rd_valid = rd && (mdl_q.size() > 0) && !soft_reset;
        if (exp_rd_valid) exp_rd_data = mdl_q[0];
        @(posedge clock);
        if (soft_reset) begin
            mdl_q.delete();
        end else begin
            if (exp_rd_valid) void'(mdl_q.pop_front());
            if (exp_wr_valid) mdl_q.push_back(din);
        end
        #1;
        write_enb = 1'b0;
        read_enb = 1'b0;
        lfd_state = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h exp 00", data_out); end
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        step(1, 0, 1, 8'h0D);
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        step(1, 0, 0, 8'h3F);
        step(0, 1, 0, 8'h00);
        n_vec++; if (data_out !== 8'h0D) begin n_err++; $display("FAIL ar_hdr got %h exp 0D", data_out); end
        step(0, 0, 0, 8'h00);
        n_vec++; if (data_out !== 8'h0D) begin n_err++; $display("FAIL ar_hold got %h exp 0D", data_out); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ar_empty got %b exp 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL ar_full got %b exp 0", full); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL ar_dout got %h exp 00", data_out); end
        #1 reset = 1'b0;
        mdl_q.delete();
        step(0, 1, 0, 8'h00);
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL ar_rd_after got %h exp 00", data_out); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ar_empty_after got %b exp 1", empty); end
    endtask

    task automatic test_packet();
        logic [7:0] pat [5];
        pat = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3F};
        for (int i = 0; i < 5; i++) step(1, 0, (i == 0), pat[i]);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00);
            n_vec++; if (data_out !== pat[i]) begin n_err++; $display("FAIL pkt_rd%0d got %h exp %h", i, data_out, pat[i]); end
        end
        step(0, 0, 0, 8'h00);
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL pkt_idle got %h exp 00", data_out); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL pkt_empty got %b exp 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 8'h30 + 8'(i));
            if (i == 14) begin
                n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL full_15 got %b exp 0", full); end
            end
        end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_16 got %b exp 1", full); end
        step(1, 0, 0, 8'hAA);
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_drop got %b exp 1", full); end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'h00);
            if (i == 0) begin
                n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL full_after_rd got %b exp 0", full); end
            end
            n_vec++; if (data_out !== 8'h30 + 8'(i)) begin n_err++; $display("FAIL full_drain%0d got %h exp %h", i, data_out, 8'h30 + 8'(i)); end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_empty got %b exp 1", empty); end
        step(0, 1, 0, 8'h00);
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL full_no_aa got %h exp 00", data_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h50 + 8'(i));
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 8'h60 + 8'(k));
            exp = (k < 8) ? 8'h50 + 8'(k) : 8'h60 + 8'(k - 8);
            n_vec++; if (data_out !== exp) begin n_err++; $display("FAIL b2b_rd%0d got %h exp %h", k, data_out, exp); end
            n_vec++; if (empty !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL b2b_flags%0d got e%b f%b exp e0 f0", k, empty, full); end
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 8'h00);
            exp = 8'h62 + 8'(k);
            n_vec++; if (data_out !== exp) begin n_err++; $display("FAIL b2b_drain%0d got %h exp %h", k, data_out, exp); end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b exp 1", empty); end
    endtask

    task automatic test_soft_reset();
        step(1, 0, 1, 8'h14);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h41 + 8'(i));
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        n_vec++; if (data_out !== 8'h42) begin n_err++; $display("FAIL sr_hold got %h exp 42", data_out); end
        soft_reset = 1'b1;
        step(1, 1, 0, 8'h99);
        soft_reset = 1'b0;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL sr_empty got %b exp 1", empty); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL sr_dout got %h exp 00", data_out); end
        step(0, 1, 0, 8'h00);
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL sr_no_write got %h exp 00", data_out); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL sr_empty2 got %b exp 1", empty); end
    endtask

    task automatic test_stream();
        int  wr_idx = 0;
        int  rd_idx = 0;
        int  cyc = 0;
        bit  wr, rd;
        while (rd_idx < 40 && cyc < 3000) begin
            wr = (wr_idx < 40) && ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 9) < ((cyc < 60) ? 2 : 6));
            step(wr, rd, 0, 8'(wr_idx));
            if (exp_wr_valid) wr_idx++;
            if (exp_rd_valid) begin
                n_vec++; if (data_out !== 8'(rd_idx)) begin n_err++; $display("FAIL stream_rd%0d got %h exp %h", rd_idx, data_out, 8'(rd_idx)); end
                rd_idx++;
            end
            n_vec++;
            if (full !== (mdl_q.size() == 16) || empty !== (mdl_q.size() == 0)) begin
                n_err++; $display("FAIL stream_flags cyc%0d got f%b e%b exp occupancy %0d", cyc, full, empty, mdl_q.size());
            end
            cyc++;
        end
        n_vec++; if (rd_idx != 40) begin n_err++; $display("FAIL stream_timeout got %0d reads exp 40", rd_idx); end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_packet();
        test_full();
        test_back_to_back();
        test_soft_reset();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
